// File: rtl/bram_arb_pkg.sv
// Shared types and default constants for the BRAM ownership arbiter.
package bram_arb_pkg;

   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_ROW_W     = 13;
   localparam int DEF_GUARD_CYC = 4;
   localparam int DEF_IMEM_ROWS = 5120;

   // Ownership phases: CPU and HOST own the BRAM.
   // RESUME and DRAIN are dead windows between owners.
   typedef enum logic [1:0] {
      ST_RESUME = 2'd0,
      ST_CPU    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HOST   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Metastability filter: first flop may go metastable, second resolves it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/bram_arbiter.sv
// Hands a dual-port BRAM back and forth between the CPU and an external host.
// The CPU is held in reset whenever it does not own the memory, and every
// handoff passes through a GUARD_CYC-cycle dead window with all writes off.
// Optional build macro BRAM_ARB_IMEM_GUARD_EN: blocks CPU writes into the
// instruction-memory rows (below IMEM_ROWS) and raises a sticky fault.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int ROW_W     = DEF_ROW_W,
   parameter int GUARD_CYC = DEF_GUARD_CYC,
   parameter int IMEM_ROWS = DEF_IMEM_ROWS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] cpu_addra,
   input  logic [ADDR_W-1:0] cpu_addrb,
   input  logic [3:0]        cpu_web,
   input  logic [31:0]       cpu_dib,
   input  logic [ADDR_W-1:0] mem_addra,
   input  logic [ADDR_W-1:0] mem_addrb,
   input  logic [3:0]        mem_wea,
   input  logic [31:0]       mem_dia,
   output logic [ROW_W-1:0]  row_a,
   output logic [ROW_W-1:0]  row_b,
   output logic [3:0]        wea,
   output logic [3:0]        web,
   output logic [31:0]       dia,
   output logic [31:0]       dib,
   output logic              cpu_rst_n,
   output logic              mem_grant,
   output logic              fault
);

   localparam int                CNT_W    = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(GUARD_CYC - 1);

   arb_state_t        r_state;
   arb_state_t        w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_host_req_s;
   logic              r_cpu_rst_n;
   logic              r_mem_grant;
   logic [ROW_W-1:0]  w_cpu_row_a;
   logic [ROW_W-1:0]  w_cpu_row_b;
   logic [ROW_W-1:0]  w_mem_row_a;
   logic [ROW_W-1:0]  w_mem_row_b;
   logic [3:0]        w_cpu_web;

   sync2 u_sync_host_req (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (host_req),
      .o_q   (w_host_req_s)
   );

   // Byte address to 32-bit word row; high bits beyond ROW_W are dropped.
   assign w_cpu_row_a = cpu_addra[ROW_W+1:2];
   assign w_cpu_row_b = cpu_addrb[ROW_W+1:2];
   assign w_mem_row_a = mem_addra[ROW_W+1:2];
   assign w_mem_row_b = mem_addrb[ROW_W+1:2];

   // Write data is never muxed; only the enables decide who actually writes.
   assign dia = mem_dia;
   assign dib = cpu_dib;

`ifdef BRAM_ARB_IMEM_GUARD_EN
   localparam logic [ROW_W-1:0] IMEM_LIMIT = ROW_W'(IMEM_ROWS);

   logic w_imem_hit;
   logic r_fault;

   assign w_imem_hit = (w_cpu_row_b < IMEM_LIMIT);
   assign w_cpu_web  = w_imem_hit ? 4'h0 : cpu_web;

   // Remember any CPU attempt to write instruction memory until next reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault <= 1'b0;
      end else if ((r_state == ST_CPU) && (cpu_web != 4'h0) && w_imem_hit) begin
         r_fault <= 1'b1;
      end
   end

   assign fault = r_fault;
`else
   assign w_cpu_web = cpu_web;
   assign fault     = 1'b0;
`endif

   // State, guard counter and the registered ownership outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RESUME;
         r_cnt       <= '0;
         r_cpu_rst_n <= 1'b0;
         r_mem_grant <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_cpu_rst_n <= (w_state_next == ST_CPU);
         r_mem_grant <= (w_state_next == ST_HOST);
      end
   end

   // Next-state logic; guard windows run a fixed length and ignore host_req.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = '0;
      unique case (r_state)
         ST_RESUME: begin
            if (r_cnt == CNT_LAST) begin
               w_state_next = ST_CPU;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_CPU: begin
            if (w_host_req_s) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (r_cnt == CNT_LAST) begin
               w_state_next = ST_HOST;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_HOST: begin
            if (!w_host_req_s) begin
               w_state_next = ST_RESUME;
            end
         end
         default: begin
            w_state_next = ST_RESUME;
         end
      endcase
   end

   // Row and enable muxing straight from the current owner; writes are off
   // in both guard windows so a reset (which forces RESUME) kills them at once.
   always_comb begin
      row_a = w_cpu_row_a;
      row_b = w_cpu_row_b;
      wea   = 4'h0;
      web   = 4'h0;
      unique case (r_state)
         ST_CPU: begin
            web = w_cpu_web;
         end
         ST_HOST: begin
            row_a = w_mem_row_a;
            row_b = w_mem_row_b;
            wea   = mem_wea;
         end
         default: begin
            row_a = w_cpu_row_a;
            row_b = w_cpu_row_b;
         end
      endcase
   end

   assign cpu_rst_n = r_cpu_rst_n;
   assign mem_grant = r_mem_grant;

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomised scoreboard bench for bram_arbiter. Build with
// BRAM_ARB_IMEM_GUARD_EN defined to exercise the instruction-memory guard.
module tb_bram_arbiter;

   localparam int GUARD = 4;
   localparam int IMEM  = 5120;
   localparam int NCYC  = 3000;

   localparam int PH_RESUME = 0;
   localparam int PH_CPU    = 1;
   localparam int PH_DRAIN  = 2;
   localparam int PH_HOST   = 3;

   logic        clk;
   logic        rst_n;
   logic        host_req;
   logic [15:0] cpu_addra, cpu_addrb, mem_addra, mem_addrb;
   logic [3:0]  cpu_web, mem_wea;
   logic [31:0] cpu_dib, mem_dia;
   logic [12:0] row_a, row_b;
   logic [3:0]  wea, web;
   logic [31:0] dia, dib;
   logic        cpu_rst_n, mem_grant, fault;

   bram_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .host_req  (host_req),
      .cpu_addra (cpu_addra),
      .cpu_addrb (cpu_addrb),
      .cpu_web   (cpu_web),
      .cpu_dib   (cpu_dib),
      .mem_addra (mem_addra),
      .mem_addrb (mem_addrb),
      .mem_wea   (mem_wea),
      .mem_dia   (mem_dia),
      .row_a     (row_a),
      .row_b     (row_b),
      .wea       (wea),
      .web       (web),
      .dia       (dia),
      .dib       (dib),
      .cpu_rst_n (cpu_rst_n),
      .mem_grant (mem_grant),
      .fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [12:0] row_a;
      logic [12:0] row_b;
      logic [3:0]  wea;
      logic [3:0]  web;
      logic [31:0] dia;
      logic [31:0] dib;
      logic        cpu_rst_n;
      logic        mem_grant;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: owner phase, cycles spent in it, 2-deep host_req delay.
   int   m_phase;
   int   m_age;
   bit   m_dly[$];
   bit   m_fault;
   bit   m_crst;
   bit   m_grant;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [12:0] row_of(input logic [15:0] a);
      logic [15:0] w;
      w = a >> 2;
      return w[12:0];
   endfunction

   function automatic bit guard_on();
`ifdef BRAM_ARB_IMEM_GUARD_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_phase = PH_RESUME;
      m_age   = 0;
      m_dly   = '{1'b0, 1'b0};
      m_fault = 1'b0;
      m_crst  = 1'b0;
      m_grant = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs held across it.
   task automatic model_step();
      bit seen;
      if (!rst_n) begin
         model_reset();
         return;
      end
      seen = m_dly.pop_front();
      m_dly.push_back(host_req);
      if (guard_on() && m_phase == PH_CPU && cpu_web != 4'h0 && int'(row_of(cpu_addrb)) < IMEM)
         m_fault = 1'b1;
      case (m_phase)
         PH_RESUME, PH_DRAIN: begin
            m_age++;
            if (m_age == GUARD) begin
               m_phase = (m_phase == PH_RESUME) ? PH_CPU : PH_HOST;
               m_age   = 0;
            end
         end
         PH_CPU:  if (seen)  m_phase = PH_DRAIN;
         default: if (!seen) m_phase = PH_RESUME;
      endcase
      m_crst  = (m_phase == PH_CPU);
      m_grant = (m_phase == PH_HOST);
   endtask

   task automatic push_expected();
      exp_t e;
      bit   host_owns;
      host_owns   = (m_phase == PH_HOST);
      e.row_a     = host_owns ? row_of(mem_addra) : row_of(cpu_addra);
      e.row_b     = host_owns ? row_of(mem_addrb) : row_of(cpu_addrb);
      e.wea       = host_owns ? mem_wea : 4'h0;
      e.web       = 4'h0;
      if (m_phase == PH_CPU)
         e.web = (guard_on() && int'(row_of(cpu_addrb)) < IMEM) ? 4'h0 : cpu_web;
      e.dia       = mem_dia;
      e.dib       = cpu_dib;
      e.cpu_rst_n = m_crst;
      e.mem_grant = m_grant;
      e.fault     = m_fault;
      exp_q.push_back(e);
   endtask

   // Monitor: compare the DUT against the oldest expectation every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("row_a",     32'(row_a),     32'(e.row_a));
            check("row_b",     32'(row_b),     32'(e.row_b));
            check("wea",       32'(wea),       32'(e.wea));
            check("web",       32'(web),       32'(e.web));
            check("dia",       dia,            e.dia);
            check("dib",       dib,            e.dib);
            check("cpu_rst_n", 32'(cpu_rst_n), 32'(e.cpu_rst_n));
            check("mem_grant", 32'(mem_grant), 32'(e.mem_grant));
            check("fault",     32'(fault),     32'(e.fault));
         end
      end
   end

   // Stimulus: random buses, host_req held in random-length runs.
   initial begin
      int  seg_left;
      int  rst_hold;
      int  n_resets;
      bit  did_route;
      rst_n     = 1'b0;
      host_req  = 1'b0;
      cpu_addra = '0; cpu_addrb = '0; mem_addra = '0; mem_addrb = '0;
      cpu_web   = 4'hF; mem_wea = 4'hF;
      cpu_dib   = '0; mem_dia = '0;
      seg_left  = 10;
      rst_hold  = 0;
      n_resets  = 0;
      did_route = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("rst_mem_grant", 32'(mem_grant), 32'd0);
      check("rst_fault",     32'(fault),     32'd0);
      check("rst_wea",       32'(wea),       32'd0);
      check("rst_web",       32'(web),       32'd0);
      rst_n = 1'b1;
      push_expected();

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         model_step();
         #1;
         cpu_addra = 16'($urandom);
         cpu_addrb = 16'($urandom);
         mem_addra = 16'($urandom);
         mem_addrb = 16'($urandom);
         cpu_web   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         mem_wea   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         cpu_dib   = $urandom;
         mem_dia   = $urandom;
         if (seg_left == 0) begin
            host_req = ~host_req;
            seg_left = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 30);
         end
         seg_left--;

         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
            push_expected();
         end else if (m_phase == PH_HOST && !did_route) begin
            mem_addra = 16'h0010;
            mem_wea   = 4'hF;
            did_route = 1'b1;
            #1;
            check("route_row_a", 32'(row_a), 32'd4);
            check("route_wea",   32'(wea),   32'hF);
            check("route_web",   32'(web),   32'd0);
            push_expected();
         end else if (m_phase == PH_HOST && did_route && n_resets < 3 &&
                      $urandom_range(0, 19) == 0) begin
            mem_wea = 4'hF;
            rst_n   = 1'b0;
            #1;
            check("midhost_wea",       32'(wea),       32'd0);
            check("midhost_mem_grant", 32'(mem_grant), 32'd0);
            check("midhost_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
            model_reset();
            n_resets++;
            rst_hold = 2;
            push_expected();
         end else begin
            push_expected();
         end
      end

      repeat (2) @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
